// File: rtl/correlation_peak_detector.sv
// rtl/correlation_peak_detector.sv - per-window best-match search over 10-bit correlator words
// Emits the window's peak score and first-peak index, plus a saturating detect counter.
module correlation_peak_detector #(
  parameter int WINDOW    = 8,
  parameter int THRESHOLD = 8,
  localparam int IW       = $clog2(WINDOW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [9:0]    corr,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_peak,
  output logic [IW-1:0] res_index,
  output logic          res_detect,
  output logic [7:0]    det_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(WINDOW - 1);
  localparam logic [3:0]    THR      = 4'(THRESHOLD);

  logic [IW-1:0] idx_q;
  logic [3:0]    best_q;
  logic [IW-1:0] best_idx_q;
  logic          res_valid_q;
  logic [3:0]    res_peak_q;
  logic [IW-1:0] res_index_q;
  logic          res_detect_q;
  logic [7:0]    det_count_q;

  logic [3:0]    ones;
  logic [3:0]    score;
  logic [3:0]    best_d;
  logic [IW-1:0] best_idx_d;
  logic          detect_d;
  logic          accept;
  logic          last;

  assign in_ready = !clear && (!res_valid_q || res_ready);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (idx_q == LAST_IDX);

  // A zero bit in the correlator word is a chip match.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, corr[i]};
    end
    score = 4'd10 - ones;
  end

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if (idx_q == '0) begin
      best_d     = score;
      best_idx_d = '0;
    end else if (score > best_q) begin
      best_d     = score;
      best_idx_d = idx_q;
    end
    detect_d = (best_d >= THR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_q       <= 4'd0;
      best_idx_q   <= '0;
      res_valid_q  <= 1'b0;
      res_peak_q   <= 4'd0;
      res_index_q  <= '0;
      res_detect_q <= 1'b0;
      det_count_q  <= 8'd0;
    end else begin
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (clear) begin
        idx_q      <= '0;
        best_q     <= 4'd0;
        best_idx_q <= '0;
      end else if (accept) begin
        best_q     <= best_d;
        best_idx_q <= best_idx_d;
        if (last) begin
          idx_q        <= '0;
          res_valid_q  <= 1'b1;
          res_peak_q   <= best_d;
          res_index_q  <= best_idx_d;
          res_detect_q <= detect_d;
          if (detect_d && (det_count_q != 8'hFF)) begin
            det_count_q <= det_count_q + 8'd1;
          end
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign res_valid  = res_valid_q;
  assign res_peak   = res_peak_q;
  assign res_index  = res_index_q;
  assign res_detect = res_detect_q;
  assign det_count  = det_count_q;

endmodule

// File: doc/correlation_peak_detector.md
Name: correlation_peak_detector

Overview:
- Sits directly downstream of the 10-bit correlator and consumes its stream of correlation words.
- Per word, match score = number of zero bits in the word (0..10).
- Over each window of WINDOW accepted words, tracks the best score and its position in the window.
- Emits one result per window through a valid/ready handshake, plus a saturating count of windows that met THRESHOLD.

Parameters:
- WINDOW, 8, words per window; legal range 2..256. Index width IW = clog2(WINDOW), computed as a localparam.
- THRESHOLD, 8, minimum peak score that sets res_detect; legal range 0..10.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of the current window.
- in_valid  input  1  correlation word present.
- in_ready  output  1  block can accept a word this cycle.
- corr  input  10  correlation word from the correlator.
- res_valid  output  1  result held for the consumer.
- res_ready  input  1  consumer takes the result.
- res_peak  output  4  best match score in the window (0..10).
- res_index  output  IW  in-window position (0-based) of the first word that reached res_peak.
- res_detect  output  1  res_peak >= THRESHOLD.
- det_count  output  8  windows with res_detect=1; saturates at 255.

Behaviour:
- Reset: rst_n low clears all state immediately, without waiting for a clock.
  - All outputs go to 0 except in_ready, which is 1 once clear is low.
  - Internal window index and running best also go to 0.
  - A partial window is discarded. A pending result is dropped and is not counted again.
- in_ready = !clear && (!res_valid || res_ready). Purely combinational; no registered stall.
- Accept: a word is accepted in a cycle where in_valid && in_ready.
- Score: score = 10 - popcount(corr). Computed combinationally; 4-bit unsigned.
- Window state: index counter idx (0..WINDOW-1), best score, best_idx.
- On accept with idx==0: best <= score, best_idx <= 0.
- On accept with idx>0: update best and best_idx only if score > best (strict). Ties keep the earliest index.
- On accept with idx==WINDOW-1, final values include the current word. At that edge:
  - res_peak and res_index are loaded.
  - res_detect is loaded as (final best >= THRESHOLD).
  - res_valid <= 1.
  - idx <= 0.
  - If detect is set, det_count increments, saturating at 255.
- Any other accept: idx <= idx+1.
- Latency: result is visible the cycle after the last word of its window is accepted.
- Output hold: res_* are stable while res_valid=1 and res_ready=0.
- Result handshake: res_valid && res_ready retires the result, and res_valid <= 0, unless a new window completes on the same edge. In that case res_valid stays 1 and res_* take the new values. No bubble, no loss.
- Backpressure: while res_valid=1 and res_ready=0, in_ready=0. At most one window result is ever pending. Upstream must hold corr stable while in_valid=1 and in_ready=0.
- clear:
  - Takes priority over accept: any word presented in that cycle is not accepted.
  - idx <= 0 and best <= 0.
  - res_valid, res_*, and det_count are unaffected, so a pending result still completes its handshake.
- in_valid=0: no state change except the result handshake.
- No X propagation from corr when in_valid=0; no state depends on corr unless a word is accepted.

Test Plan:
- Reset/idle (WINDOW=4, THRESHOLD=8): assert rst_n=0 mid-clock -> all outputs 0 immediately; after release, in_ready=1 and res_valid=0 for 10 idle cycles.
- Basic window, res_ready=1: corr=3FF,000,3FE,001 (scores 0,10,1,9) -> one cycle after the 4th accept: res_valid=1, res_peak=10, res_index=1, res_detect=1, det_count=1.
- Ties and no detect: corr=0F0 four times (score 6 each) -> res_peak=6, res_index=0, res_detect=0, det_count unchanged.
- Backpressure and back-to-back: hold res_ready=0 with a result pending -> in_ready=0, words not accepted, res_* stable for 5 cycles. Then raise res_ready and stream 4 words continuously -> next result appears with no gap and no lost window.
- Clear mid-window: accept 000,000, then pulse clear while in_valid=1 with corr=000 -> that word is not taken. Then feed 3FF,3FF,003,3FF -> res_peak=8, res_index=2, det_count increments.
- Saturation and async reset: 256 windows of 000 -> det_count stops at 255. Then drop rst_n with res_valid=1 and idx=2 -> res_valid, det_count and idx are 0 before the next clock edge.
